// File: rtl/alarm_button_conditioner.sv
// Alarm-clock key front end: per-key synchroniser, debouncer and event-pulse
// generator, with auto-repeat on the up/down keys.

module alarm_button_channel #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned HOLD_CYCLES     = 25000000,
    parameter int unsigned REPEAT_CYCLES   = 5000000,
    parameter int unsigned PULSE_CYCLES    = 50000,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter bit          REPEAT_EN       = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_pulse,
    output logic o_held
);

    localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned PW   = $clog2(PULSE_CYCLES + 1);
    localparam int unsigned TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    localparam logic [DW-1:0] DB_TC    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PULSE_LD = PW'(PULSE_CYCLES);
    localparam logic [TW-1:0] HOLD_TC  = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REP_TC   = TW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_HOLD,
        S_REPEAT,
        S_HELD
    } state_t;

    logic [1:0]    r_sync;
    logic          r_stable;
    logic [DW-1:0] r_dcnt;
    logic [PW-1:0] r_pcnt;
    logic [TW-1:0] r_tcnt;
    state_t        r_state;

    logic w_p;
    logic w_accept;
    logic w_rise;
    logic w_fall;
    logic w_event;

    assign w_p      = r_sync[1] ^ ACTIVE_LOW;
    assign w_accept = (w_p != r_stable) && (r_dcnt == DB_TC);
    assign w_rise   = w_accept && w_p;
    assign w_fall   = w_accept && !w_p;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync   <= {2{ACTIVE_LOW}};
            r_stable <= 1'b0;
            r_dcnt   <= '0;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            if (w_p == r_stable) begin
                r_dcnt <= '0;
            end else if (r_dcnt == DB_TC) begin
                r_stable <= w_p;
                r_dcnt   <= '0;
            end else begin
                r_dcnt <= r_dcnt + DW'(1);
            end
        end
    end

    // Events fire on the debounce accept strobe so the pulse rises on the same
    // edge as stable; a release on a terminal-count edge suppresses that repeat.
    always_comb begin
        w_event = 1'b0;
        case (r_state)
            S_IDLE:      w_event = w_rise;
            S_WAIT_HOLD: w_event = !w_fall && (r_tcnt == HOLD_TC);
            S_REPEAT:    w_event = !w_fall && (r_tcnt == REP_TC);
            default:     w_event = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_tcnt  <= '0;
            r_pcnt  <= '0;
        end else begin
            if (w_event) begin
                r_pcnt <= PULSE_LD;
            end else if (r_pcnt != '0) begin
                r_pcnt <= r_pcnt - PW'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        r_tcnt  <= '0;
                        r_state <= REPEAT_EN ? S_WAIT_HOLD : S_HELD;
                    end
                end
                S_WAIT_HOLD: begin
                    if (w_fall) begin
                        r_state <= S_IDLE;
                    end else if (r_tcnt == HOLD_TC) begin
                        r_tcnt  <= '0;
                        r_state <= S_REPEAT;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                S_REPEAT: begin
                    if (w_fall) begin
                        r_state <= S_IDLE;
                    end else if (r_tcnt == REP_TC) begin
                        r_tcnt <= '0;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                default: begin
                    if (w_fall) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign o_pulse = (r_pcnt != '0);
    assign o_held  = r_stable;

endmodule

module alarm_button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned HOLD_CYCLES     = 25000000,
    parameter int unsigned REPEAT_CYCLES   = 5000000,
    parameter int unsigned PULSE_CYCLES    = 50000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       key_set_raw,
    input  logic       key_up_raw,
    input  logic       key_down_raw,
    output logic       btn_set_alarm_export,
    output logic       btn_up_export,
    output logic       btn_down_export,
    output logic [2:0] keys_held
);

    logic w_held_set;
    logic w_held_up;
    logic w_held_down;

    alarm_button_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES),
        .PULSE_CYCLES    (PULSE_CYCLES),
        .ACTIVE_LOW      (ACTIVE_LOW),
        .REPEAT_EN       (1'b0)
    ) u_set (
        .i_clk   (clk_clk),
        .i_rst   (reset_reset),
        .i_raw   (key_set_raw),
        .o_pulse (btn_set_alarm_export),
        .o_held  (w_held_set)
    );

    alarm_button_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES),
        .PULSE_CYCLES    (PULSE_CYCLES),
        .ACTIVE_LOW      (ACTIVE_LOW),
        .REPEAT_EN       (1'b1)
    ) u_up (
        .i_clk   (clk_clk),
        .i_rst   (reset_reset),
        .i_raw   (key_up_raw),
        .o_pulse (btn_up_export),
        .o_held  (w_held_up)
    );

    alarm_button_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES),
        .PULSE_CYCLES    (PULSE_CYCLES),
        .ACTIVE_LOW      (ACTIVE_LOW),
        .REPEAT_EN       (1'b1)
    ) u_down (
        .i_clk   (clk_clk),
        .i_rst   (reset_reset),
        .i_raw   (key_down_raw),
        .o_pulse (btn_down_export),
        .o_held  (w_held_down)
    );

    assign keys_held = {w_held_down, w_held_up, w_held_set};

endmodule

// File: tb/tb_alarm_button_conditioner.sv
// Directed bench for alarm_button_conditioner: per-edge expected vectors are
// queued as stimulus is driven and compared once the edge has been taken.

module tb_alarm_button_conditioner;

    localparam int unsigned DB   = 4;
    localparam int unsigned HOLD = 10;
    localparam int unsigned REP  = 5;
    localparam int unsigned PUL  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       ks, ku, kd;
    logic       o_set, o_up, o_down;
    logic [2:0] held;

    always #5 clk = ~clk;

    alarm_button_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .HOLD_CYCLES     (HOLD),
        .REPEAT_CYCLES   (REP),
        .PULSE_CYCLES    (PUL),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk_clk              (clk),
        .reset_reset          (rst),
        .key_set_raw          (ks),
        .key_up_raw           (ku),
        .key_down_raw         (kd),
        .btn_set_alarm_export (o_set),
        .btn_up_export        (o_up),
        .btn_down_export      (o_down),
        .keys_held            (held)
    );

    // Expected behaviour per test: event start edges and held intervals per
    // channel (0 = set, 1 = up, 2 = down), plus a reset window forcing zeros.
    int ev [3][8];
    int nev [3];
    int ha0 [3], ha1 [3], hb0 [3], hb1 [3];
    int rst_a, rst_b;

    int errors = 0;
    int checks = 0;
    string cur_tag;

    typedef struct {
        logic [5:0] v;
        int         k;
    } exp_t;
    exp_t sb [$];

    task automatic clear_model();
        for (int c = 0; c < 3; c++) begin
            nev[c] = 0;
            ha0[c] = 0; ha1[c] = 0;
            hb0[c] = 0; hb1[c] = 0;
        end
        rst_a = -10;
        rst_b = -10;
    endtask

    function automatic logic in_rst(input int k);
        return (k >= rst_a) && (k <= rst_b);
    endfunction

    function automatic logic pulse_exp(input int c, input int k);
        logic r;
        r = 1'b0;
        for (int i = 0; i < nev[c]; i++)
            if (k >= ev[c][i] && k < ev[c][i] + int'(PUL)) r = 1'b1;
        return r && !in_rst(k);
    endfunction

    function automatic logic held_exp(input int c, input int k);
        logic r;
        r = (k >= ha0[c] && k < ha1[c]) || (k >= hb0[c] && k < hb1[c]);
        return r && !in_rst(k);
    endfunction

    task automatic check(input logic [5:0] exp, input int k);
        logic [5:0] obs;
        obs = {o_set, o_up, o_down, held};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s edge=%0d observed={set,up,down,held}=%b expected=%b",
                   cur_tag, k, obs, exp);
        end
    endtask

    task automatic cycle(input int k, input logic s, input logic u, input logic d, input logic r);
        exp_t e;
        exp_t got;
        @(negedge clk);
        ks = s; ku = u; kd = d; rst = r;
        e.v = {pulse_exp(0, k), pulse_exp(1, k), pulse_exp(2, k),
               held_exp(2, k), held_exp(1, k), held_exp(0, k)};
        e.k = k;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check(got.v, got.k);
    endtask

    task automatic reset_dut();
        cur_tag = "reset_state";
        @(negedge clk);
        rst = 1'b1; ks = 1'b1; ku = 1'b1; kd = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check(6'b000000, -1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cur_tag = "post_reset_idle";
        check(6'b000000, -1);
    endtask

    initial begin
        rst = 1'b1; ks = 1'b1; ku = 1'b1; kd = 1'b1;
        reset_dut();

        // Single up press held for 8 cycles
        cur_tag = "single_press";
        clear_model();
        ev[1][0] = 5; nev[1] = 1;
        ha0[1] = 5; ha1[1] = 13;
        for (int k = 0; k < 25; k++)
            cycle(k, 1'b1, (k < 8) ? 1'b0 : 1'b1, 1'b1, 1'b0);

        reset_dut();

        // Set key bouncing every cycle, then released
        cur_tag = "bounce";
        clear_model();
        for (int k = 0; k < 25; k++)
            cycle(k, (k < 10 && (k % 2) == 0) ? 1'b0 : 1'b1, 1'b1, 1'b1, 1'b0);

        reset_dut();

        // Down held 40 cycles: press event plus auto-repeat train
        cur_tag = "auto_repeat";
        clear_model();
        ev[2][0] = 5;  ev[2][1] = 15; ev[2][2] = 20; ev[2][3] = 25;
        ev[2][4] = 30; ev[2][5] = 35; ev[2][6] = 40; nev[2] = 7;
        ha0[2] = 5; ha1[2] = 45;
        for (int k = 0; k < 55; k++)
            cycle(k, 1'b1, 1'b1, (k < 40) ? 1'b0 : 1'b1, 1'b0);

        reset_dut();

        // Set-alarm held 40 cycles: single pulse, no repeat
        cur_tag = "set_held";
        clear_model();
        ev[0][0] = 5; nev[0] = 1;
        ha0[0] = 5; ha1[0] = 45;
        for (int k = 0; k < 55; k++)
            cycle(k, (k < 40) ? 1'b0 : 1'b1, 1'b1, 1'b1, 1'b0);

        reset_dut();

        // Up and down together: independent, coincident trains
        cur_tag = "simultaneous";
        clear_model();
        for (int c = 1; c < 3; c++) begin
            ev[c][0] = 5;  ev[c][1] = 15; ev[c][2] = 20; ev[c][3] = 25;
            ev[c][4] = 30; ev[c][5] = 35; ev[c][6] = 40; nev[c] = 7;
            ha0[c] = 5; ha1[c] = 45;
        end
        for (int k = 0; k < 55; k++)
            cycle(k, 1'b1, (k < 40) ? 1'b0 : 1'b1, (k < 40) ? 1'b0 : 1'b1, 1'b0);

        reset_dut();

        // Reset at edges 16-17 while up is held; key still low afterwards
        cur_tag = "reset_mid_press";
        clear_model();
        ev[1][0] = 5;  ev[1][1] = 15; ev[1][2] = 23;
        ev[1][3] = 33; ev[1][4] = 38; nev[1] = 5;
        ha0[1] = 5;  ha1[1] = 16;
        hb0[1] = 23; hb1[1] = 1000;
        rst_a = 16; rst_b = 17;
        for (int k = 0; k < 40; k++)
            cycle(k, 1'b1, 1'b0, 1'b1, (k == 16 || k == 17) ? 1'b1 : 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alarm_button_conditioner.md
Name: alarm_button_conditioner

Overview:
- Upstream input stage for the alarm-clock SoC, sitting between the three raw board keys and the processor's button PIO inputs (set-alarm, up, down).
- Per key: synchronises the raw input, debounces it, and converts each debounced press into a stretched event pulse that software polling can see.
- The up and down keys also auto-repeat while held, so the time can be scrolled quickly.
- Outputs drive btn_set_alarm_export, btn_up_export and btn_down_export on the system directly.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a level change (10 ms at 50 MHz); must be >= 2.
- HOLD_CYCLES, 25000000, cycles from the press event to the first auto-repeat event (500 ms).
- REPEAT_CYCLES, 5000000, cycles between subsequent auto-repeat events (100 ms); must be > PULSE_CYCLES.
- PULSE_CYCLES, 50000, cycles each event output is held high (1 ms); must be >= 1.
- ACTIVE_LOW, 1, 1 = raw key reads 0 when pressed.

Ports:
- clk_clk  input  1  system clock.
- reset_reset  input  1  synchronous active-high reset.
- key_set_raw  input  1  raw set-alarm key, asynchronous.
- key_up_raw  input  1  raw up key, asynchronous.
- key_down_raw  input  1  raw down key, asynchronous.
- btn_set_alarm_export  output  1  set-alarm event pulse, active high.
- btn_up_export  output  1  up event pulse, active high, auto-repeats.
- btn_down_export  output  1  down event pulse, active high, auto-repeats.
- keys_held  output  3  debounced pressed levels {down, up, set}, active high.

Behaviour:
Clock and reset:
- Single clock domain clk_clk. Reset is synchronous and active-high on reset_reset.

Reset state (everything registered):
- All outputs 0.
- Synchroniser flops reset to the released level: 1 if ACTIVE_LOW, else 0.
- All counters 0. Every channel FSM in IDLE.

Per-channel datapath (three identical instances; set-alarm has repeat disabled):
- Synchroniser: two-flop chain; p = second flop XOR ACTIVE_LOW (1 = pressed).
- Debounce:
  - If p == stable, cnt <= 0.
  - Otherwise cnt increments. When cnt == DEBOUNCE_CYCLES-1 and the mismatch persists, stable <= p and cnt <= 0.
  - Any mismatch-free cycle restarts the count. A glitch shorter than DEBOUNCE_CYCLES never changes stable.
- Latency: raw press first sampled at edge 0 -> stable and the event rise at edge DEBOUNCE_CYCLES+1.
- keys_held bit = stable.

Event generation:
- An event loads pcnt <= PULSE_CYCLES. Output = (pcnt != 0); pcnt decrements to 0.
- An event arriving while pcnt != 0 reloads pcnt. The output stays high and no gap is inserted.

Channel FSM:
- IDLE:
  - stable rises -> emit event, tcnt <= 0.
  - Go to WAIT_HOLD for up/down, or HELD for set-alarm.
- WAIT_HOLD: tcnt increments each cycle.
  - tcnt == HOLD_CYCLES-1 -> emit event, tcnt <= 0, go to REPEAT.
  - stable falls -> IDLE.
- REPEAT: tcnt increments each cycle.
  - tcnt == REPEAT_CYCLES-1 -> emit event, tcnt <= 0.
  - stable falls -> IDLE.
- HELD: stable falls -> IDLE.
- Release never truncates a pulse already in progress; pcnt runs out normally.
- First repeat event at edge DEBOUNCE_CYCLES+1+HOLD_CYCLES; later events spaced every REPEAT_CYCLES.

Boundary conditions:
- Channels are fully independent. Simultaneous presses produce simultaneous pulses; there is no priority and no mutual exclusion.
- Counter widths are sized by $clog2 of the relevant parameter (+1 where needed). Counters never wrap in use: tcnt is cleared at each terminal count.
- Reset asserted mid-press or mid-pulse: outputs drop to 0 on the next edge.
- A key still held when reset releases is treated as a new press. Its event is emitted DEBOUNCE_CYCLES+1 edges after the first post-reset edge.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=5, PULSE_CYCLES=2, ACTIVE_LOW=1. All edges below are counted from the first edge that samples the raw change.
1. Single press of key_up_raw (0 at edge 0, held 8 cycles, then released):
   - btn_up_export is high after edges 5 and 6, low from edge 7.
   - keys_held[1] is high from edge 5.
   - After release, keys_held[1] clears 5 edges later.
   - No further pulses.
2. Bounce: key_set_raw toggles 0/1 every cycle for 10 cycles, then settles at 1:
   - btn_set_alarm_export and keys_held stay 0 throughout.
3. Auto-repeat: key_down_raw held low for 40 cycles:
   - btn_down_export rises at edges 5, 15, 20, 25, 30, 35, 40, 2 cycles each.
   - Nothing after the release debounce completes.
4. Set-alarm held low for 40 cycles:
   - Exactly one 2-cycle pulse starting at edge 5; no repeats.
5. Simultaneous press of key_up_raw and key_down_raw:
   - Identical, coincident pulse trains on btn_up_export and btn_down_export.
   - keys_held = 3'b110.
6. Reset while key_up_raw is held and pulsing:
   - Reset asserted at edge 16: all outputs 0 at edge 16.
   - Reset released with the key still low: a new pulse starts 5 edges after the first post-reset edge.
